// File: rtl/cvt_fp_pkg.sv
// cvt_fp_pkg: shared definitions for the int<->float converter.
//   - default format widths (32-bit word, 8-bit exponent, 23-bit fraction)
//   - fp_bias(): exponent bias for a given exponent width
//   - INT_MAX / INT_MIN saturation patterns for the default word width
//   - flag_e: encoding of the (mutually exclusive) NaN / INF result flags
//   - float_t: unpacked {sign, exp, frac} view of a default-width float
package cvt_fp_pkg;

  localparam int DEF_LOGWIDTH  = 5;
  localparam int DEF_EXPWIDTH  = 8;
  localparam int DEF_MANTWIDTH = 23;
  localparam int DEF_W         = 2 ** DEF_LOGWIDTH;

  function automatic int fp_bias(input int expwidth);
    return (2 ** (expwidth - 1)) - 1;
  endfunction

  localparam logic [DEF_W-1:0] INT_MAX = {1'b0, {(DEF_W-1){1'b1}}};
  localparam logic [DEF_W-1:0] INT_MIN = {1'b1, {(DEF_W-1){1'b0}}};

  // At most one flag is ever raised, so a single encoded field is enough.
  typedef enum logic [1:0] {
    FLAG_NONE = 2'b00,
    FLAG_NAN  = 2'b01,
    FLAG_INF  = 2'b10
  } flag_e;

  typedef struct packed {
    logic                     sign;
    logic [DEF_EXPWIDTH-1:0]  exp;
    logic [DEF_MANTWIDTH-1:0] frac;
  } float_t;

endpackage

// File: rtl/cvt_fp_lzc.sv
// cvt_fp_lzc: combinational leading-zero counter.
// Ports:
//   din   in  W            word to scan
//   count out LOGWIDTH+1   number of leading zeros (W when din is zero)
module cvt_fp_lzc #(
  parameter int LOGWIDTH = 5,
  parameter int W        = 2 ** LOGWIDTH
) (
  input  logic [W-1:0]      din,
  output logic [LOGWIDTH:0] count
);

  typedef logic [LOGWIDTH:0] cnt_t;

  // Ascending scan: the highest set bit is the last one to write count.
  always_comb begin
    count = cnt_t'(W);
    for (int i = 0; i < W; i++) begin
      if (din[i]) count = cnt_t'(W - 1 - i);
    end
  end

endmodule

// File: rtl/cvt_fp.sv
// cvt_fp: registered converter between signed words and IEEE754 floats.
// Ports:
//   clk    in  1  clock, rising edge
//   reset  in  1  synchronous active-high reset (priority over ciENA)
//   diA    in  W  signed integer (ciWay=0) or float pattern (ciWay=1)
//   ciWay  in  1  0 = word-to-float, 1 = float-to-word
//   ciENA  in  1  result registers load only when 1
//   doY    out W  registered result
//   doNAN  out 1  registered flag: float input was NaN
//   doINF  out 1  registered flag: float input infinite / out of integer range
// Build option: define CVT_FP_RNE_EN to make float-to-word round to nearest
// even instead of truncating toward zero.
module cvt_fp
  import cvt_fp_pkg::*;
#(
  parameter int LOGWIDTH  = DEF_LOGWIDTH,
  parameter int EXPWIDTH  = DEF_EXPWIDTH,
  parameter int MANTWIDTH = DEF_MANTWIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [2**LOGWIDTH-1:0]   diA,
  input  logic                     ciWay,
  input  logic                     ciENA,
  output logic [2**LOGWIDTH-1:0]   doY,
  output logic                     doNAN,
  output logic                     doINF
);

  localparam int W    = 2 ** LOGWIDTH;
  localparam int BIAS = fp_bias(EXPWIDTH);

  if (EXPWIDTH + MANTWIDTH + 1 != W) begin : g_bad_format
    $error("cvt_fp: EXPWIDTH+MANTWIDTH+1 must equal 2**LOGWIDTH");
  end
  if (EXPWIDTH < 3) begin : g_bad_expwidth
    $error("cvt_fp: EXPWIDTH must be at least 3");
  end

  typedef logic [EXPWIDTH-1:0]  exp_t;
  typedef logic [LOGWIDTH:0]    sh_t;
  typedef logic [MANTWIDTH:0]   mr_t;

  // Biased exponent of 2**(W-1): top of integer range.
  localparam exp_t EXP_TOP = exp_t'(BIAS + W - 1);

  localparam logic [W-1:0] SAT_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SAT_NEG = {1'b1, {(W-1){1'b0}}};

  // ---------------- word to float ----------------
  logic                 w_sign;
  logic [W-1:0]         w_mag;
  logic [LOGWIDTH:0]    w_lzc;
  logic [W-1:0]         w_norm;
  logic [MANTWIDTH-1:0] w_mant;
  logic                 w_guard, w_round, w_sticky, w_round_up;
  mr_t                  w_mant_rnd;
  exp_t                 w_exp;
  logic [W-1:0]         w_result;

  assign w_sign = diA[W-1];
  // -INT_MIN wraps to itself, which read unsigned is the correct magnitude.
  assign w_mag  = w_sign ? -diA : diA;

  cvt_fp_lzc #(.LOGWIDTH(LOGWIDTH), .W(W)) u_lzc (
    .din   (w_mag),
    .count (w_lzc)
  );

  always_comb begin
    w_norm     = w_mag << w_lzc;
    w_mant     = w_norm[W-2 -: MANTWIDTH];
    w_guard    = w_norm[W-2-MANTWIDTH];
    w_round    = w_norm[W-3-MANTWIDTH];
    w_sticky   = |w_norm[W-4-MANTWIDTH:0];
    w_round_up = w_guard & (w_round | w_sticky | w_mant[0]);
    w_mant_rnd = {1'b0, w_mant} + mr_t'(w_round_up);
    // A carry out of the mantissa leaves the fraction all zeros; bump exp.
    w_exp      = EXP_TOP - exp_t'(w_lzc) + exp_t'(w_mant_rnd[MANTWIDTH]);
    // The normalized MSB is clear only for a zero input.
    w_result   = w_norm[W-1] ? {w_sign, w_exp, w_mant_rnd[MANTWIDTH-1:0]} : '0;
  end

  // ---------------- float to word ----------------
  logic                 f_sign;
  exp_t                 f_exp;
  logic [MANTWIDTH-1:0] f_frac;
  logic [W-1:0]         f_aligned;
  sh_t                  f_sh;
  logic [W-1:0]         f_mag;
  logic [W-1:0]         f_result;
  flag_e                f_flag;

  assign f_sign    = diA[W-1];
  assign f_exp     = diA[W-2 -: EXPWIDTH];
  assign f_frac    = diA[MANTWIDTH-1:0];
  // Significand with the hidden one at bit W-1: value = f_aligned >> (W-1-e).
  assign f_aligned = {1'b1, f_frac, {(W-1-MANTWIDTH){1'b0}}};
  // Only meaningful inside the in-range branches below (1..W).
  assign f_sh      = sh_t'(EXP_TOP - f_exp);

`ifdef CVT_FP_RNE_EN
  localparam exp_t EXP_HALF = exp_t'(BIAS - 1);
  logic [2*W-1:0] f_wide;
  logic           f_guard, f_sticky, f_round_up;

  always_comb begin
    f_wide     = {f_aligned, {W{1'b0}}} >> f_sh;
    f_guard    = f_wide[W-1];
    f_sticky   = |f_wide[W-2:0];
    f_round_up = f_guard & (f_sticky | f_wide[W]);
    // Integer part is below 2**(W-1), so the sum fits in W bits.
    f_mag      = f_wide[2*W-1:W] + {{(W-1){1'b0}}, f_round_up};
  end
`else
  assign f_mag = f_aligned >> f_sh;
`endif

  always_comb begin
    f_result = '0;
    f_flag   = FLAG_NONE;
    if (&f_exp) begin
      if (f_frac != '0) begin
        f_result = SAT_POS;
        f_flag   = FLAG_NAN;
      end else begin
        f_result = f_sign ? SAT_NEG : SAT_POS;
        f_flag   = FLAG_INF;
      end
    end else if (f_exp >= EXP_TOP) begin
      if (f_sign && (f_exp == EXP_TOP) && (f_frac == '0)) begin
        f_result = SAT_NEG;   // exactly -2**(W-1) is representable
      end else begin
        f_result = f_sign ? SAT_NEG : SAT_POS;
        f_flag   = FLAG_INF;
      end
`ifdef CVT_FP_RNE_EN
    end else if (f_exp >= EXP_HALF) begin
      if (!f_sign && f_mag[W-1]) begin
        f_result = SAT_POS;   // rounded up past INT_MAX
        f_flag   = FLAG_INF;
      end else begin
        f_result = f_sign ? -f_mag : f_mag;
      end
`else
    end else if (f_exp >= exp_t'(BIAS)) begin
      f_result = f_sign ? -f_mag : f_mag;
`endif
    end
  end

  // ---------------- output registers ----------------
  logic [W-1:0] y_reg, y_next;
  flag_e        flag_reg, flag_next;

  assign y_next    = ciWay ? f_result : w_result;
  assign flag_next = ciWay ? f_flag : FLAG_NONE;

  always_ff @(posedge clk) begin
    if (reset) begin
      y_reg    <= '0;
      flag_reg <= FLAG_NONE;
    end else if (ciENA) begin
      y_reg    <= y_next;
      flag_reg <= flag_next;
    end
  end

  assign doY   = y_reg;
  assign doNAN = (flag_reg == FLAG_NAN);
  assign doINF = (flag_reg == FLAG_INF);

endmodule

// File: tb/tb_cvt_fp.sv
// tb_cvt_fp: directed-vector scoreboard bench for cvt_fp.
// Every driven cycle pushes its expected output; a monitor pops one entry
// per clock after the edge and compares it with the registered outputs.
module tb_cvt_fp;

  logic        clk;
  logic        reset;
  logic [31:0] diA;
  logic        ciWay;
  logic        ciENA;
  logic [31:0] doY;
  logic        doNAN;
  logic        doINF;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic [31:0] y;
    logic        nan;
    logic        inf;
  } sb_entry_t;

  sb_entry_t sb[$];

  cvt_fp dut (
    .clk   (clk),
    .reset (reset),
    .diA   (diA),
    .ciWay (ciWay),
    .ciENA (ciENA),
    .doY   (doY),
    .doNAN (doNAN),
    .doINF (doINF)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drive(input logic rst, input logic en, input logic way,
                       input logic [31:0] a, input logic [31:0] ey,
                       input logic enan, input logic einf, input string nm);
    @(negedge clk);
    reset = rst;
    ciENA = en;
    ciWay = way;
    diA   = a;
    sb.push_back('{name: nm, y: ey, nan: enan, inf: einf});
  endtask

  task automatic w2f(input logic [31:0] a, input logic [31:0] ey, input string nm);
    drive(1'b0, 1'b1, 1'b0, a, ey, 1'b0, 1'b0, nm);
  endtask

  task automatic f2w(input logic [31:0] a, input logic [31:0] ey,
                     input logic enan, input logic einf, input string nm);
    drive(1'b0, 1'b1, 1'b1, a, ey, enan, einf, nm);
  endtask

  // Monitor: one expected entry per driven cycle, checked just after the edge.
  initial begin
    sb_entry_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_checks++;
        if (doY !== e.y || doNAN !== e.nan || doINF !== e.inf) begin
          n_fail++;
          $display("FAIL %s: got y=%h nan=%b inf=%b, expected y=%h nan=%b inf=%b",
                   e.name, doY, doNAN, doINF, e.y, e.nan, e.inf);
        end else begin
          $display("ok   %s: y=%h nan=%b inf=%b", e.name, doY, doNAN, doINF);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    ciENA = 1'b0;
    ciWay = 1'b0;
    diA   = '0;

    // Reset, load, hold, reset priority over enable
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "reset");
    w2f(32'h00000001, 32'h3F800000, "w2f_1");
    drive(1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h3F800000, 1'b0, 1'b0, "hold");
    drive(1'b1, 1'b1, 1'b0, 32'h00000001, 32'h0, 1'b0, 1'b0, "reset_prio");

    // Word to float
    w2f(32'h00000000, 32'h00000000, "w2f_zero");
    w2f(32'hFFFFFFFF, 32'hBF800000, "w2f_m1");
    w2f(32'h80000000, 32'hCF000000, "w2f_intmin");
    w2f(32'h01000001, 32'h4B800000, "w2f_tie_even");
    w2f(32'h01000003, 32'h4B800002, "w2f_tie_up");
    w2f(32'h7FFFFFFF, 32'h4F000000, "w2f_carry");
    w2f(32'h00000005, 32'h40A00000, "w2f_5");

    // Float to word
    f2w(32'h40490FDB, 32'h00000003, 1'b0, 1'b0, "f2w_pi");
    f2w(32'hC0200000, 32'hFFFFFFFE, 1'b0, 1'b0, "f2w_m2p5");
    f2w(32'h3F000000, 32'h00000000, 1'b0, 1'b0, "f2w_half");
    f2w(32'h00000001, 32'h00000000, 1'b0, 1'b0, "f2w_denorm");
    f2w(32'h3F800000, 32'h00000001, 1'b0, 1'b0, "f2w_1");
    f2w(32'hBF800000, 32'hFFFFFFFF, 1'b0, 1'b0, "f2w_m1");
`ifdef CVT_FP_RNE_EN
    f2w(32'h3FC00000, 32'h00000002, 1'b0, 1'b0, "f2w_1p5");
`else
    f2w(32'h3FC00000, 32'h00000001, 1'b0, 1'b0, "f2w_1p5");
`endif

    // Specials
    f2w(32'h7FC00000, 32'h7FFFFFFF, 1'b1, 1'b0, "f2w_qnan");
    f2w(32'hFFC00000, 32'h7FFFFFFF, 1'b1, 1'b0, "f2w_negnan");
    f2w(32'h7F800000, 32'h7FFFFFFF, 1'b0, 1'b1, "f2w_pinf");
    f2w(32'hFF800000, 32'h80000000, 1'b0, 1'b1, "f2w_ninf");

    // Range edges
    f2w(32'h4F000000, 32'h7FFFFFFF, 1'b0, 1'b1, "f2w_2p31");
    f2w(32'h4EFFFFFF, 32'h7FFFFF80, 1'b0, 1'b0, "f2w_below");
    f2w(32'hCF000000, 32'h80000000, 1'b0, 1'b0, "f2w_intmin");
    f2w(32'hCF000001, 32'h80000000, 1'b0, 1'b1, "f2w_negovf");

    // Back-to-back, alternating direction
    w2f(32'h00000003, 32'h40400000, "b2b_w2f_3");
    f2w(32'h40A00000, 32'h00000005, 1'b0, 1'b0, "b2b_f2w_5");
    w2f(32'hFFFFFFFE, 32'hC0000000, "b2b_w2f_m2");
    f2w(32'h7FC00000, 32'h7FFFFFFF, 1'b1, 1'b0, "b2b_f2w_nan");
    w2f(32'h00000007, 32'h40E00000, "b2b_w2f_7");
    f2w(32'hC0200000, 32'hFFFFFFFE, 1'b0, 1'b0, "b2b_f2w_m2p5");

    @(negedge clk);
    ciENA = 1'b0;
    repeat (4) @(negedge clk);

    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending entries, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
